// File: rtl/fetch_prefetch_unit.sv
// Fetch/prefetch stage: owns the fetch PC, issues in-order requests to a latency-tolerant
// instruction memory, buffers returned words in a small FIFO and flushes everything on redirect.
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc4
);
    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [CW:0]     MAX_OUT_W  = (CW+1)'(MAX_OUT);
    localparam logic [CW-1:0]   FULL       = CW'(DEPTH);
    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] rspPc;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   live;
    logic [CW-1:0]   stale;
    logic [XLEN-1:0] pcMem    [DEPTH];
    logic [31:0]     instrMem [DEPTH];

    logic [XLEN-1:0] redirectBase;
    logic [CW:0]     fillSum;
    logic [CW:0]     flightSum;
    logic            headValid;
    logic            reqFire;
    logic            rspFire;
    logic            rspStale;
    logic            rspLive;
    logic            push;
    logic            pop;

    assign redirectBase = redirect_pc & ALIGN_MASK;
    assign fillSum      = {1'b0, count} + {1'b0, live};
    assign flightSum    = {1'b0, live} + {1'b0, stale};
    assign headValid    = (count != '0);

    // A FIFO slot is reserved at issue time, so a returning word always has room.
    assign imem_req_valid = rst_n && (fillSum < DEPTH_W) && (flightSum < MAX_OUT_W);
    assign imem_req_addr  = fetchPc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign rspFire  = imem_rsp_valid && (flightSum != '0);
    assign rspStale = rspFire && (stale != '0);
    assign rspLive  = rspFire && (stale == '0);
    assign push     = rspLive && !redirect_valid;
    assign pop      = headValid && instr_ready && !redirect_valid;

    assign instr_valid = headValid;
    assign instr       = headValid ? instrMem[rdPtr] : NOP;
    assign instr_pc    = headValid ? pcMem[rdPtr] : rspPc;
    assign instr_pc4   = instr_pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc <= RESET_PC;
            rspPc   <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            live    <= '0;
            stale   <= '0;
        end else if (redirect_valid) begin
            fetchPc <= redirectBase;
            rspPc   <= redirectBase;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            live    <= '0;
            // Everything still owed by memory after this edge belongs to the old path.
            stale   <= stale + live + CW'(reqFire) - CW'(rspFire);
        end else begin
            if (reqFire) fetchPc <= fetchPc + PC_STEP;
            if (push) begin
                rspPc <= rspPc + PC_STEP;
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            live  <= live + CW'(reqFire) - CW'(rspLive);
            stale <= stale - CW'(rspStale);
        end
    end

    // NOTE: FIFO storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]    <= rspPc;
            instrMem[wrPtr] <= imem_rsp_data;
        end
    end

    noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == FULL)));
    noOrphanResponse: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (flightSum == '0)));

endmodule
